instr_issue_queue: RTL and testbench

- Parametrised instruction buffer and issuer that sits between a program loader (bench or boot ROM) and the multicycle core `top`.
- Replaces the hard-coded per-instruction delays with a DEPTH-entry FIFO.
- Presents each instruction to the core for a programmable number of clock cycles, with a start strobe.
- Detects a programmable end-of-file word and halts issue.

---
 rtl/proc_pkg.sv | 15 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/instr_issue_queue.sv | 124 ++++++++++++
 tb/tb_instr_issue_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the program loader, the issue queue and the multicycle core.
package proc_pkg;

  localparam int IW_DEF = 16;
  localparam logic [15:0] EOF_DEF   = 16'h0000;
  localparam logic [15:0] INSTR_EOF = EOF_DEF;
  localparam logic [15:0] INSTR_NOP = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } issue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Parametrised synchronous FIFO with registered count, sticky overflow on dropped pushes,
// and a combinational head word.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Storage is data only; pointers being cleared is enough to discard it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers loader instructions and presents each to the core for HOLD_CYCLES cycles,
// halting once EOF_WORD is issued. Define ISSUE_CNT_EN to add the issue_count port.
module instr_issue_queue
  import proc_pkg::*;
#(
  parameter int          IW          = IW_DEF,
  parameter int          DEPTH       = 8,
  parameter int          HOLD_CYCLES = 6,
  parameter logic [IW-1:0] EOF_WORD  = IW'(EOF_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [IW-1:0]          instruction,
  output logic                   instr_start,
  output logic                   busy,
  output logic                   halted
`ifdef ISSUE_CNT_EN
  ,
  output logic [15:0]            issue_count
`endif
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  issue_state_t   state;
  issue_state_t   state_nxt;
  logic [HCW-1:0] hold_cnt;
  logic           pop;
  logic           issue_ok;
  logic [IW-1:0]  head;

  sync_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign issue_ok = run && !empty;
  assign busy     = (state == HOLD);
  assign halted   = (state == HALT);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue_ok) begin
          pop       = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // End of hold window: EOF check takes precedence over a back-to-back issue.
        if (hold_cnt == '0) begin
          if (instruction == EOF_WORD) begin
            state_nxt = HALT;
          end else if (issue_ok) begin
            pop       = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      instruction <= '0;
      instr_start <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      instr_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_start <= pop;
      if (pop) begin
        instruction <= head;
        hold_cnt    <= HOLD_LOAD;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

`ifdef ISSUE_CNT_EN
  // Counts alongside instr_start; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      issue_count <= '0;
    else if (flush)
      issue_count <= '0;
    else if (pop)
      issue_count <= issue_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue (DEPTH=4, HOLD_CYCLES=6) with hand-computed expectations.
module tb_instr_issue_queue;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, empty, overflow, instr_start, busy, halted;
  logic [2:0]  count;
  logic [15:0] instruction;
`ifdef ISSUE_CNT_EN
  logic [15:0] issue_count;
`endif

  int nvec = 0;
  int nerr = 0;

  int          ns;
  int          nbusy;
  int          starts [8];
  logic [15:0] words  [8];

  always #5 clk = ~clk;

  instr_issue_queue #(
    .IW          (16),
    .DEPTH       (4),
    .HOLD_CYCLES (6),
    .EOF_WORD    (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .instruction (instruction),
    .instr_start (instr_start),
    .busy        (busy),
    .halted      (halted)
`ifdef ISSUE_CNT_EN
    ,
    .issue_count (issue_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles with inputs as set, recording issue pulses and busy cycles.
  task automatic observe(input int n);
    ns = 0;
    nbusy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (instr_start && ns < 8) begin
        starts[ns] = i;
        words[ns]  = instruction;
        ns++;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    logic [15:0] v3 [3];
    logic [15:0] v5 [5];
    v3 = '{16'h4142, 16'h4402, 16'h0253};
    v5 = '{16'h5206, 16'h9205, 16'hD504, 16'h1504, 16'h2203};

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    chk("rst_instruction", 32'(instruction), 32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Three back-to-back instructions with run=1
    run = 1'b1;
    ns = 0;
    nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      wr_en   = (i < 3);
      wr_data = (i < 3) ? v3[i] : 16'h0;
      @(negedge clk);
      if (instr_start && ns < 8) begin
        starts[ns] = i;
        words[ns]  = instruction;
        ns++;
      end
      if (busy) nbusy++;
    end
    wr_en = 1'b0;
    chk("seq_nstarts", 32'(ns), 32'd3);
    chk("seq_first_latency", 32'(starts[0]), 32'd1);
    chk("seq_gap01", 32'(starts[1] - starts[0]), 32'd6);
    chk("seq_gap12", 32'(starts[2] - starts[1]), 32'd6);
    chk("seq_word0", 32'(words[0]), 32'h4142);
    chk("seq_word1", 32'(words[1]), 32'h4402);
    chk("seq_word2", 32'(words[2]), 32'h0253);
    chk("seq_busy_cycles", 32'(nbusy), 32'd18);
    chk("seq_idle_busy", 32'(busy), 32'd0);
    chk("seq_idle_instr", 32'(instruction), 32'h0253);
    chk("seq_empty", 32'(empty), 32'd1);
`ifdef ISSUE_CNT_EN
    chk("seq_issue_count", 32'(issue_count), 32'd3);
`endif

    // Fill with run=0, fifth push dropped
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_word(v5[k]);
      chk("fill_count", 32'(count), (k < 4) ? 32'(k + 1) : 32'd4);
      chk("fill_full", 32'(full), (k >= 3) ? 32'd1 : 32'd0);
      chk("fill_overflow", 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("fill_no_issue", 32'(busy), 32'd0);
    run = 1'b1;
    observe(30);
    chk("drain_nstarts", 32'(ns), 32'd4);
    chk("drain_first", 32'(starts[0]), 32'd0);
    chk("drain_word0", 32'(words[0]), 32'h5206);
    chk("drain_word1", 32'(words[1]), 32'h9205);
    chk("drain_word2", 32'(words[2]), 32'hD504);
    chk("drain_word3", 32'(words[3]), 32'h1504);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_overflow_sticky", 32'(overflow), 32'd1);

    // EOF halts issue; remaining word stays queued
    run = 1'b0;
    push_word(16'h5206);
    push_word(INSTR_EOF);
    push_word(16'h9205);
    run = 1'b1;
    observe(30);
    chk("eof_nstarts", 32'(ns), 32'd2);
    chk("eof_word1", 32'(words[1]), 32'h0000);
    chk("eof_halted", 32'(halted), 32'd1);
    chk("eof_busy", 32'(busy), 32'd0);
    chk("eof_count", 32'(count), 32'd1);
    chk("eof_instr_kept", 32'(instruction), 32'h0000);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_halted", 32'(halted), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
`ifdef ISSUE_CNT_EN
    chk("flush_issue_count", 32'(issue_count), 32'd0);
`endif

    // run drops two cycles into a hold
    run = 1'b0;
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    run = 1'b1;
    @(negedge clk);
    chk("pause_start", 32'(instr_start), 32'd1);
    chk("pause_word", 32'(instruction), 32'h1111);
    @(negedge clk);
    run = 1'b0;
    observe(12);
    chk("pause_nstarts", 32'(ns), 32'd0);
    chk("pause_busy_rest", 32'(nbusy), 32'd4);
    chk("pause_count", 32'(count), 32'd2);
    run = 1'b1;
    @(negedge clk);
    chk("resume_start", 32'(instr_start), 32'd1);
    chk("resume_word", 32'(instruction), 32'h2222);

    // Asynchronous reset between edges, mid-hold
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_instruction", 32'(instruction), 32'h0);
    chk("arst_empty", 32'(empty), 32'd1);
`ifdef ISSUE_CNT_EN
    chk("arst_issue_count", 32'(issue_count), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_start", 32'(instr_start), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
